// File: rtl/prog_loader.sv
// prog_loader: turns a host word stream into imem/dmem preload writes, then starts the core.
// Define PROG_LOADER_CSUM_EN to require a trailing XOR checksum word per non-empty block.
module prog_loader #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            host_valid_i,
    input  logic [XLEN-1:0] host_data_i,
    output logic            host_ready_o,
    output logic [XLEN-1:0] imem_wr_addr,
    output logic [XLEN-1:0] imem_wr_data,
    output logic            imem_wr_valid,
    output logic [XLEN-1:0] dmem_wr_addr,
    output logic [XLEN-1:0] dmem_wr_data,
    output logic            dmem_wr_valid,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_start_minus4,
    output logic            err_o,
    output logic            busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        PC,
        RUN,
        ERR
`ifdef PROG_LOADER_CSUM_EN
        ,
        CSUM
`endif
    } state_t;

    state_t stateQ, stateD;

    logic [CNT_W-1:0] cntQ;
    logic [XLEN-1:0]  addrQ;
    logic             dmemSelQ;
`ifdef PROG_LOADER_CSUM_EN
    logic [XLEN-1:0]  csumQ;
`endif

    logic             accept;
    logic [1:0]       hdrType;
    logic [CNT_W-1:0] hdrCnt;
    logic             misaligned;
    logic             lastWord;
    logic             blockD;

    assign accept     = host_valid_i & host_ready_o;
    assign hdrType    = host_data_i[XLEN-1 -: 2];
    assign hdrCnt     = host_data_i[CNT_W-1:0];
    assign misaligned = (host_data_i[1:0] != 2'b00);
    assign lastWord   = (cntQ == CNT_W'(1));

    always_comb begin
        stateD = stateQ;
        if (accept) begin
            case (stateQ)
                IDLE: begin
                    unique case (1'b1)
                        (hdrType == 2'b10): stateD = PC;
                        (hdrType == 2'b11): stateD = ERR;
                        default:            stateD = ADDR;
                    endcase
                end
                ADDR: begin
                    if (misaligned)
                        stateD = ERR;
                    else if (cntQ == '0)
                        stateD = IDLE;
                    else
                        stateD = DATA;
                end
                DATA: begin
`ifdef PROG_LOADER_CSUM_EN
                    if (lastWord) stateD = CSUM;
`else
                    if (lastWord) stateD = IDLE;
`endif
                end
`ifdef PROG_LOADER_CSUM_EN
                CSUM: stateD = (host_data_i == csumQ) ? IDLE : ERR;
`endif
                PC:      stateD = misaligned ? ERR : RUN;
                default: ;
            endcase
        end
    end

`ifdef PROG_LOADER_CSUM_EN
    assign blockD = (stateD == ADDR) || (stateD == DATA) || (stateD == CSUM);
`else
    assign blockD = (stateD == ADDR) || (stateD == DATA);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stateQ <= IDLE;
        else        stateQ <= stateD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_ready_o    <= 1'b0;
            imem_wr_addr    <= '0;
            imem_wr_data    <= '0;
            imem_wr_valid   <= 1'b0;
            dmem_wr_addr    <= '0;
            dmem_wr_data    <= '0;
            dmem_wr_valid   <= 1'b0;
            pc_valid_o      <= 1'b0;
            pc_start_minus4 <= '0;
            err_o           <= 1'b0;
            busy_o          <= 1'b0;
            cntQ            <= '0;
            addrQ           <= '0;
            dmemSelQ        <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
            csumQ           <= '0;
`endif
        end else begin
            imem_wr_valid <= 1'b0;
            dmem_wr_valid <= 1'b0;
            host_ready_o  <= (stateD != RUN);
            busy_o        <= blockD;
            err_o         <= (stateD == ERR);
            if (accept) begin
                case (stateQ)
                    IDLE: begin
                        dmemSelQ <= (hdrType == 2'b01);
                        cntQ     <= hdrCnt;
                    end
                    ADDR: begin
                        addrQ <= host_data_i;
`ifdef PROG_LOADER_CSUM_EN
                        csumQ <= '0;
`endif
                    end
                    DATA: begin
                        if (dmemSelQ) begin
                            dmem_wr_valid <= 1'b1;
                            dmem_wr_addr  <= addrQ;
                            dmem_wr_data  <= host_data_i;
                        end else begin
                            imem_wr_valid <= 1'b1;
                            imem_wr_addr  <= addrQ;
                            imem_wr_data  <= host_data_i;
                        end
                        addrQ <= addrQ + XLEN'(4);
                        cntQ  <= cntQ - CNT_W'(1);
`ifdef PROG_LOADER_CSUM_EN
                        csumQ <= csumQ ^ host_data_i;
`endif
                    end
                    PC: begin
                        if (!misaligned) begin
                            pc_valid_o      <= 1'b1;
                            pc_start_minus4 <= host_data_i - XLEN'(4);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: per-cycle vector table, hand corner sequences,
// and a randomized block stream scored against a write-list model.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_valid_i = 1'b0;
    logic [31:0] host_data_i = '0;
    logic        host_ready_o;
    logic [31:0] imem_wr_addr, imem_wr_data;
    logic        imem_wr_valid;
    logic [31:0] dmem_wr_addr, dmem_wr_data;
    logic        dmem_wr_valid;
    logic        pc_valid_o;
    logic [31:0] pc_start_minus4;
    logic        err_o, busy_o;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n),
        .host_valid_i(host_valid_i), .host_data_i(host_data_i),
        .host_ready_o(host_ready_o),
        .imem_wr_addr(imem_wr_addr), .imem_wr_data(imem_wr_data),
        .imem_wr_valid(imem_wr_valid),
        .dmem_wr_addr(dmem_wr_addr), .dmem_wr_data(dmem_wr_data),
        .dmem_wr_valid(dmem_wr_valid),
        .pc_valid_o(pc_valid_o), .pc_start_minus4(pc_start_minus4),
        .err_o(err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

`ifdef PROG_LOADER_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    int errors = 0;
    int checks = 0;
    int gapMax = 0;

    typedef struct {
        bit          dm;
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t actQ[$];
    wr_t expQ[$];
    bit  mon = 1'b0;
    int  bothHigh = 0;

    always @(negedge clk) begin
        if (mon) begin
            if (imem_wr_valid && dmem_wr_valid) bothHigh++;
            if (imem_wr_valid) actQ.push_back('{1'b0, imem_wr_addr, imem_wr_data});
            if (dmem_wr_valid) actQ.push_back('{1'b1, dmem_wr_addr, dmem_wr_data});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        host_valid_i = 1'b0;
        host_data_i = '0;
        @(posedge clk); #1;
        chk("rst ready", 32'(host_ready_o), 0);
        chk("rst imem_v", 32'(imem_wr_valid), 0);
        chk("rst dmem_v", 32'(dmem_wr_valid), 0);
        chk("rst busy", 32'(busy_o), 0);
        chk("rst err", 32'(err_o), 0);
        chk("rst pcv", 32'(pc_valid_o), 0);
        chk("rst pc", pc_start_minus4, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post-rst ready", 32'(host_ready_o), 1);
    endtask

    task automatic send(input logic [31:0] w);
        int g;
        bit acc;
        g = $urandom_range(0, gapMax);
        repeat (g) begin
            host_valid_i = 1'b0;
            host_data_i = $urandom;
            @(posedge clk); #1;
        end
        host_valid_i = 1'b1;
        host_data_i = w;
        for (int t = 0; t < 20; t++) begin
            acc = host_ready_o;
            @(posedge clk); #1;
            if (acc) begin
                host_valid_i = 1'b0;
                return;
            end
        end
        host_valid_i = 1'b0;
        checks++;
        errors++;
        $display("FAIL send timeout: word %h never accepted", w);
    endtask

    typedef struct {
        bit          rst;
        bit          v;
        logic [31:0] d;
        bit          iv;
        bit          dv;
        logic [31:0] wa;
        logic [31:0] wd;
        bit          rdy;
        bit          bsy;
        bit          er;
        bit          pcv;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(bit rst, bit v, logic [31:0] d, bit iv, bit dv,
                                logic [31:0] wa, logic [31:0] wd, bit rdy,
                                bit bsy, bit er, bit pcv, logic [31:0] pc);
        mk = '{rst, v, d, iv, dv, wa, wd, rdy, bsy, er, pcv, pc};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        logic [31:0] x;
        int n;
        bit dm;
        logic [31:0] base, d;

`ifndef PROG_LOADER_CSUM_EN
        // IMEM block of 3
        vecs.push_back(mk(1, 1, 32'h3, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hA, 1, 0, 32'h100, 32'hA, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hB, 1, 0, 32'h104, 32'hB, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hC, 1, 0, 32'h108, 32'hC, 1, 0, 0, 0, 0));
        // DMEM block of 2, then START at 0x100
        vecs.push_back(mk(0, 1, 32'h4000_0002, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h200, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h11, 0, 1, 32'h200, 32'h11, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h22, 0, 1, 32'h204, 32'h22, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFC));
        vecs.push_back(mk(0, 1, 32'h5, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFC));
        // N=0 block, then a wrapping block
        vecs.push_back(mk(1, 1, 32'h0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h400, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h2, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h77, 1, 0, 32'hFFFF_FFFC, 32'h77, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h88, 1, 0, 32'h0, 32'h88, 1, 0, 0, 0, 0));
        // reserved type, then absorbed words
        vecs.push_back(mk(1, 1, 32'hC000_0001, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h3, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'hA, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // misaligned base
        vecs.push_back(mk(1, 1, 32'h1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h102, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h5, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // misaligned start PC
        vecs.push_back(mk(1, 1, 32'h8000_0000, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h101, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100, 0, 0, 0, 0, 1, 0, 1, 0, 0));
`endif

        doReset();
        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            host_valid_i = vecs[i].v;
            host_data_i = vecs[i].d;
            @(posedge clk); #1;
            host_valid_i = 1'b0;
            chk($sformatf("v%0d imem_v", i), 32'(imem_wr_valid), 32'(vecs[i].iv));
            chk($sformatf("v%0d dmem_v", i), 32'(dmem_wr_valid), 32'(vecs[i].dv));
            if (vecs[i].iv) begin
                chk($sformatf("v%0d imem_a", i), imem_wr_addr, vecs[i].wa);
                chk($sformatf("v%0d imem_d", i), imem_wr_data, vecs[i].wd);
            end
            if (vecs[i].dv) begin
                chk($sformatf("v%0d dmem_a", i), dmem_wr_addr, vecs[i].wa);
                chk($sformatf("v%0d dmem_d", i), dmem_wr_data, vecs[i].wd);
            end
            chk($sformatf("v%0d ready", i), 32'(host_ready_o), 32'(vecs[i].rdy));
            chk($sformatf("v%0d busy", i), 32'(busy_o), 32'(vecs[i].bsy));
            chk($sformatf("v%0d err", i), 32'(err_o), 32'(vecs[i].er));
            chk($sformatf("v%0d pcv", i), 32'(pc_valid_o), 32'(vecs[i].pcv));
            chk($sformatf("v%0d pc", i), pc_start_minus4, vecs[i].pc);
        end

        // reset in the middle of a 4-word block
        doReset();
        gapMax = 0;
        send(32'h0000_0004);
        send(32'h300);
        send(32'h1);
        send(32'h2);
        chk("mid imem_v", 32'(imem_wr_valid), 1);
        chk("mid imem_a", imem_wr_addr, 32'h304);
        rst_n = 1'b0;
        #1;
        chk("abort imem_v", 32'(imem_wr_valid), 0);
        chk("abort busy", 32'(busy_o), 0);
        doReset();
        actQ.delete();
        mon = 1'b1;
        send(32'h4000_0001);
        chk("post-abort hdr busy", 32'(busy_o), 1);
        send(32'h500);
        send(32'h99);
        chk("post-abort dmem_v", 32'(dmem_wr_valid), 1);
        chk("post-abort dmem_a", dmem_wr_addr, 32'h500);
        chk("post-abort dmem_d", dmem_wr_data, 32'h99);
        @(posedge clk); #1;
        mon = 1'b0;
        chk("post-abort writes", 32'(actQ.size()), 1);

`ifdef PROG_LOADER_CSUM_EN
        // good then bad checksum
        doReset();
        actQ.delete();
        mon = 1'b1;
        send(32'h2);
        send(32'h600);
        send(32'hA);
        send(32'hB);
        send(32'h1);
        chk("csum ok err", 32'(err_o), 0);
        chk("csum ok busy", 32'(busy_o), 0);
        send(32'h2);
        send(32'h600);
        send(32'hA);
        send(32'hB);
        send(32'h2);
        chk("csum bad err", 32'(err_o), 1);
        send(32'h4000_0001);
        send(32'h700);
        send(32'h5);
        @(posedge clk); #1;
        mon = 1'b0;
        chk("csum writes", 32'(actQ.size()), 4);
        chk("csum sticky err", 32'(err_o), 1);
`endif

        // randomized block stream with host gaps
        doReset();
        actQ.delete();
        expQ.delete();
        bothHigh = 0;
        gapMax = 3;
        mon = 1'b1;
        for (int b = 0; b < 25; b++) begin
            if (b == 0) begin
                dm = 1'b0;
                n = 4;
                base = 32'h1000;
            end else begin
                dm = 1'($urandom_range(0, 1));
                n = $urandom_range(0, 5);
                base = $urandom & 32'hFFFF_FFFC;
                if (b % 7 == 0) base = 32'hFFFF_FFF8;
            end
            send({(dm ? 2'b01 : 2'b00), 14'($urandom), 16'(n)});
            send(base);
            x = '0;
            for (int i = 0; i < n; i++) begin
                d = $urandom;
                x = x ^ d;
                expQ.push_back('{dm, base + 32'(4 * i), d});
                send(d);
            end
            if (CSUM && n > 0) send(x);
        end
        repeat (3) @(posedge clk);
        #1;
        mon = 1'b0;
        chk("rand count", 32'(actQ.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < actQ.size(); i++) begin
            chk($sformatf("rand w%0d port", i), 32'(actQ[i].dm), 32'(expQ[i].dm));
            chk($sformatf("rand w%0d addr", i), actQ[i].a, expQ[i].a);
            chk($sformatf("rand w%0d data", i), actQ[i].d, expQ[i].d);
        end
        chk("rand both strobes", 32'(bothHigh), 0);
        chk("rand err", 32'(err_o), 0);
        chk("rand busy", 32'(busy_o), 0);
        chk("rand ready", 32'(host_ready_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Host-side writer for the core's memory-preload and start interface.
- Consumes a 32-bit command/data word stream from the host over a valid/ready handshake.
- Drives the core's imem_wr_* and dmem_wr_* write ports, then releases the core via pc_valid_i / pc_start_minus4.
- Instantiated beside the core top; its outputs connect one-to-one to the core's loader inputs.

Parameters:
- XLEN, 32, data/address width; equals RV_BIT_NUM.
- CNT_W, 16, width of the block word-count field in the header.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- host_valid_i  in  1  host word valid.
- host_data_i  in  XLEN  host word.
- host_ready_o  out  1  loader accepts word this cycle.
- imem_wr_addr  out  XLEN  instruction memory write byte address.
- imem_wr_data  out  XLEN  instruction memory write data.
- imem_wr_valid  out  1  instruction memory write strobe.
- dmem_wr_addr  out  XLEN  data memory write byte address.
- dmem_wr_data  out  XLEN  data memory write data.
- dmem_wr_valid  out  1  data memory write strobe.
- pc_valid_o  out  1  core start enable; drives core pc_valid_i.
- pc_start_minus4  out  XLEN  start PC minus 4.
- err_o  out  1  sticky protocol error.
- busy_o  out  1  a block transfer is in progress.

Behaviour:
- Reset is asynchronous, active-low on rst_n, and applies to all flops. Reset values:
  - all outputs 0;
  - state IDLE;
  - host_ready_o 0 while rst_n low, 1 in the first cycle after release.
- A word is accepted when host_valid_i & host_ready_o. All outputs are registered.
- Header word fields:
  - [31:30] type: 00 = IMEM block, 01 = DMEM block, 10 = START, 11 = reserved.
  - [CNT_W-1:0] N = data-word count.
  - Other bits ignored.
- States:
  - IDLE: accept header.
    - Type 00/01 -> ADDR, latch type and N.
    - Type 10 -> PC.
    - Type 11 -> ERR.
  - ADDR: accept base address.
    - base[1:0] != 0 -> ERR.
    - N == 0 -> IDLE; no writes occur.
    - Otherwise -> DATA, with addr_q = base and cnt_q = N.
  - DATA: each accepted word produces a one-cycle write on the selected port in the following cycle.
    - Write fields: wr_addr = addr_q, wr_data = word, wr_valid = 1.
    - After each write, addr_q += 4 (mod 2^XLEN, wraps silently) and cnt_q -= 1.
    - When the last word is accepted (cnt_q == 1) -> IDLE.
  - PC: accept start PC.
    - pc[1:0] != 0 -> ERR.
    - Otherwise pc_start_minus4 = pc - 4 (mod 2^XLEN), and pc_valid_o rises in the next cycle. -> RUN.
  - RUN:
    - host_ready_o = 0.
    - pc_valid_o and pc_start_minus4 are held.
    - Left only by reset.
  - ERR:
    - err_o = 1, sticky.
    - host_ready_o = 1; all words are discarded.
    - No writes; pc_valid_o stays 0. Left only by reset.
- Write strobes are single-cycle pulses. imem_wr_valid and dmem_wr_valid are never high together.
- The *_wr_addr and *_wr_data outputs hold their last value when the strobe is low.
- host_ready_o is 1 in IDLE, ADDR, DATA, PC and ERR. Host gaps (valid low) stall the FSM with no side effects.
- busy_o = 1 in ADDR and DATA.
- Back-to-back throughput is one word per cycle; there is no bubble between blocks.
- Reset asserted mid-block aborts immediately:
  - any strobe in flight is cleared;
  - the partial block is not resumed;
  - the next word after release is treated as a header.

Optional Feature:
- Macro: PROG_LOADER_CSUM_EN.
- Defined:
  - Each block with N > 0 carries one extra trailing word, accepted in state CSUM after DATA.
  - The trailing word must equal the XOR of the block's N data words.
  - Mismatch -> ERR. Writes already issued are not retracted.
  - Match -> IDLE.
  - N == 0 blocks carry no checksum word.
- Undefined:
  - No CSUM state; the block ends with its last data word.
  - Any extra word is parsed as a header.

Test Plan:
1. IMEM block: words 0x0000_0003, 0x0000_0100, then 0xA, 0xB, 0xC at one per cycle -> imem_wr_valid pulses on 3 consecutive cycles, addresses 0x100/0x104/0x108, data A/B/C; dmem_wr_valid stays 0; busy_o falls after the last word.
2. DMEM block then START:
   - Stimulus: 0x4000_0002, 0x0000_0200, 0x11, 0x22, then 0x8000_0000, 0x0000_0100.
   - Response: dmem writes to 0x200/0x204.
   - Response: pc_start_minus4 = 0x0000_00FC and pc_valid_o = 1 one cycle after PC acceptance.
   - Response: host_ready_o = 0 thereafter.
3. Edge blocks:
   - N = 0 block (0x0000_0000, 0x0000_0400) -> no write strobes; the next word is decoded as a header.
   - Base 0xFFFF_FFFC with N = 2 -> addresses 0xFFFF_FFFC then 0x0000_0000.
4. Errors:
   - Header 0xC000_0001 -> err_o = 1 next cycle, subsequent words absorbed with no writes.
   - Base 0x0000_0102 -> err_o = 1.
   - START with PC 0x0000_0101 -> err_o = 1, pc_valid_o stays 0.
5. Backpressure and reset:
   - Host valid gaps of random length within a 4-word IMEM block -> identical writes to the gap-free run.
   - rst_n low after the second data word -> strobes clear, no further writes; the first post-reset word is handled as a header.
6. With PROG_LOADER_CSUM_EN defined:
   - Block 0xA, 0xB with checksum 0x1 -> both writes, no error, return to IDLE.
   - Same block with checksum 0x2 -> both writes issued, then err_o = 1.
